spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
SPI responder (slave) that pairs with the team's spi_master on the far end of the link. It oversamples SCLK, CS_n and MOSI on the system clock and supports all four CPOL/CPHA modes. It shifts out a parallel transmit word on MISO and returns each received MOSI word on a parallel port with a one-cycle valid strobe. It sits in peripheral-side logic, behind the pin interface.

Parameters:
SPI_DATA_WIDTH, 32, bits per word; must be >= 2.
SYNC_STAGES, 2, synchronizer flops on SCLK/CS_n/MOSI; must be >= 2.

Ports:
i_clock  input  1  system clock; must be >= 8x SCLK frequency.
i_reset  input  1  synchronous, active-high reset.
i_clock_polarity  input  1  CPOL.
i_clock_phase  input  1  CPHA.
i_tx_load  input  1  writes i_data_in into the TX holding register.
i_data_in  input  SPI_DATA_WIDTH  word to transmit.
o_data_out  output  SPI_DATA_WIDTH  last complete received word.
o_data_valid  output  1  one-cycle pulse when o_data_out updates.
o_busy  output  1  high while synchronized CS_n is low.
i_spi_cs_n  input  1  chip select, active low, asynchronous.
i_spi_clock  input  1  SCLK, asynchronous.
i_spi_mosi  input  1  MOSI, asynchronous.
o_spi_miso  output  1  MISO data.
o_spi_miso_oe  output  1  MISO output enable; high only while selected.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; holding, shift and bit counter cleared.
- Synchronizers: SYNC_STAGES flops, then one extra flop for edge detection. A pin change is acted on SYNC_STAGES+1 cycles later.
- Sample edge: rising when CPOL==CPHA, falling otherwise. Shift edge is the opposite SCLK edge.
- FSM IDLE: o_busy=0, oe=0, SCLK edges ignored. On synchronized CS_n falling edge:
  - latch CPOL/CPHA;
  - load the TX word (holding register, or i_data_in if i_tx_load is high in the same cycle);
  - clear bit_cnt;
  - go to ACTIVE.
- TX load, CPHA=0: miso_reg <= word[MSB]; shift <= word<<1.
- TX load, CPHA=1: miso_reg <= 0; shift <= word.
- FSM ACTIVE:
  - o_busy=1, oe=1.
  - Sample edge: rx <= {rx[W-2:0], mosi_sync}; bit_cnt++.
  - Shift edge: miso_reg <= shift[MSB]; shift <= shift<<1.
  - When bit_cnt reaches W on a sample edge: o_data_out <= the completed word (including this bit); o_data_valid=1 for that cycle; bit_cnt <= 0.
  - Word boundary (back-to-back words in one frame): the next word reloads from the holding register using the TX load rule for the latched CPHA. For CPHA=0 the reload replaces the normal shift action on the following shift edge.
- CS_n rising edge (synchronized) while ACTIVE:
  - go to IDLE; oe=0; bit_cnt cleared;
  - the partial word is discarded with no valid pulse;
  - o_data_out keeps its last value.
- Simultaneous CS_n rise and sample edge: the CS rise wins and the edge is ignored.
- i_tx_load is accepted in any state. The holding register is sticky: the same word is resent each frame until it is rewritten.
- CPOL/CPHA changes while ACTIVE have no effect until the next frame.
- Reset mid-frame returns to IDLE immediately with outputs 0. The rest of that frame is ignored until CS_n is seen high and then falling again.
- bit_cnt width is clog2(W)+1 and it never wraps past W.

Optional Feature:
SPI_SLAVE_FRAME_ERROR_EN:
- Defined: adds output o_frame_error (1 bit, reset 0).
- It pulses for one cycle when CS_n rises with bit_cnt != 0, i.e. a partial word was received.
- Also adds o_tx_stale (1 bit, reset 0), set when a word is loaded from the holding register without an i_tx_load since the previous load, and cleared on i_tx_load.
- Undefined: neither port exists and no extra logic is built.

Test Plan:
- Mode 0, SCLK period 16 cycles; holding=0xA5A5_0F0F; master sends 0x1234_5678 -> o_data_valid once; o_data_out=0x1234_5678; MISO bits read by master = 0xA5A5_0F0F; oe high only inside CS.
- Modes 1, 2, 3 repeat the mode 0 case -> identical words in both directions; CPHA=1 MSB appears on the first leading edge.
- Two words in one CS frame, second via i_tx_load=0xDEAD_BEEF during word 1 -> two valid pulses; MISO sends holding then 0xDEAD_BEEF.
- CS_n raised after 13 bits -> no valid pulse; o_data_out unchanged; with SPI_SLAVE_FRAME_ERROR_EN, o_frame_error pulses once.
- i_reset asserted mid-word (bit 20) -> outputs 0 next cycle; next full frame receives correctly.
- SCLK toggling while CS_n high -> no bit_cnt change, no valid pulse, oe=0.

Source files
------------

// File: rtl/spi_slave_if.sv
// spi_slave_if: parallel host-side bus of the SPI responder.
//   i_tx_load    - host writes i_data_in into the TX holding register
//   i_data_in    - word to transmit
//   o_data_out   - last complete word received on MOSI
//   o_data_valid - one-cycle strobe when o_data_out updates
//   o_busy       - high while the responder is inside a CS frame
// Modports: slave (the responder), master (the host driving it).
interface spi_slave_if #(
  parameter int unsigned SPI_DATA_WIDTH = 32
);
  logic                      i_tx_load;
  logic [SPI_DATA_WIDTH-1:0] i_data_in;
  logic [SPI_DATA_WIDTH-1:0] o_data_out;
  logic                      o_data_valid;
  logic                      o_busy;

  modport slave (
    input  i_tx_load, i_data_in,
    output o_data_out, o_data_valid, o_busy
  );

  modport master (
    output i_tx_load, i_data_in,
    input  o_data_out, o_data_valid, o_busy
  );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: SPI responder, all four CPOL/CPHA modes, SCLK/CS_n/MOSI
// oversampled on i_clock (i_clock must be >= 8x SCLK).
//   i_clock, i_reset          - system clock, synchronous active-high reset
//   i_clock_polarity/_phase   - CPOL/CPHA, latched at the start of each frame
//   host (spi_slave_if.slave) - TX load / RX word / valid / busy
//   i_spi_cs_n, i_spi_clock, i_spi_mosi - asynchronous pin inputs
//   o_spi_miso, o_spi_miso_oe - MISO data and its output enable
// Optional macro SPI_SLAVE_FRAME_ERROR_EN adds:
//   o_frame_error - one-cycle pulse when CS_n rises mid-word
//   o_tx_stale    - last loaded TX word was reused from the holding register
module spi_slave #(
  parameter int unsigned SPI_DATA_WIDTH = 32,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_clock_polarity,
  input  logic        i_clock_phase,
  spi_slave_if.slave  host,
  input  logic        i_spi_cs_n,
  input  logic        i_spi_clock,
  input  logic        i_spi_mosi,
  output logic        o_spi_miso,
  output logic        o_spi_miso_oe
`ifdef SPI_SLAVE_FRAME_ERROR_EN
  ,
  output logic        o_frame_error,
  output logic        o_tx_stale
`endif
);
  localparam int unsigned W  = SPI_DATA_WIDTH;
  localparam int unsigned CW = $clog2(W) + 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  // Pin synchronizers; CS_n chain resets to "selected" so a frame already in
  // progress when reset is released is never mistaken for a new CS_n fall.
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_spi_clock};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

  state_t          state_q, state_nxt;
  logic [W-1:0]    hold_q, hold_nxt;
  logic [W-1:0]    shift_q, shift_nxt;
  logic [W-1:0]    rx_q, rx_nxt;
  logic [W-1:0]    dout_q, dout_nxt;
  logic [CW-1:0]   cnt_q, cnt_nxt;
  logic            miso_q, miso_nxt;
  logic            valid_q, valid_nxt;
  logic            cpol_q, cpol_nxt;
  logic            cpha_q, cpha_nxt;
  logic            reload_q, reload_nxt;
`ifdef SPI_SLAVE_FRAME_ERROR_EN
  logic            ferr_q, ferr_nxt;
  logic            stale_q, stale_nxt;
  logic            fresh_q, fresh_nxt;
`endif

  // Scratch for the current cycle's decisions
  logic            sample_edge, shift_edge, load_word, load_cpha;
  logic [W-1:0]    tx_word;

  // Next-state and datapath
  always_comb begin
    state_nxt  = state_q;
    hold_nxt   = hold_q;
    shift_nxt  = shift_q;
    rx_nxt     = rx_q;
    dout_nxt   = dout_q;
    cnt_nxt    = cnt_q;
    miso_nxt   = miso_q;
    valid_nxt  = 1'b0;
    cpol_nxt   = cpol_q;
    cpha_nxt   = cpha_q;
    reload_nxt = reload_q;
    load_word  = 1'b0;
    load_cpha  = cpha_q;
`ifdef SPI_SLAVE_FRAME_ERROR_EN
    ferr_nxt   = 1'b0;
    stale_nxt  = stale_q;
    fresh_nxt  = fresh_q;
`endif

    // A same-cycle i_tx_load bypasses the holding register
    tx_word = host.i_tx_load ? host.i_data_in : hold_q;
    if (host.i_tx_load) hold_nxt = host.i_data_in;

    // Sample on rising edge when CPOL==CPHA, shift on the other edge
    sample_edge = (cpol_q == cpha_q) ? sclk_rise : sclk_fall;
    shift_edge  = (cpol_q == cpha_q) ? sclk_fall : sclk_rise;

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_nxt  = ACTIVE;
          cpol_nxt   = i_clock_polarity;
          cpha_nxt   = i_clock_phase;
          cnt_nxt    = '0;
          reload_nxt = 1'b0;
          load_word  = 1'b1;
          load_cpha  = i_clock_phase;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          // CS release wins over any coincident SCLK edge
          state_nxt  = IDLE;
          cnt_nxt    = '0;
          reload_nxt = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERROR_EN
          ferr_nxt   = (cnt_q != '0);
`endif
        end else begin
          if (sample_edge) begin
            rx_nxt = {rx_q[W-2:0], mosi_s};
            if (cnt_q == CW'(W - 1)) begin
              dout_nxt  = {rx_q[W-2:0], mosi_s};
              valid_nxt = 1'b1;
              cnt_nxt   = '0;
              // CPHA=1 reloads now; CPHA=0 reloads on the next shift edge
              if (cpha_q) load_word  = 1'b1;
              else        reload_nxt = 1'b1;
            end else begin
              cnt_nxt = cnt_q + CW'(1);
            end
          end
          if (shift_edge) begin
            if (reload_q) begin
              load_word  = 1'b1;
              reload_nxt = 1'b0;
            end else begin
              miso_nxt  = shift_q[W-1];
              shift_nxt = {shift_q[W-2:0], 1'b0};
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // TX load: CPHA=0 presents the MSB immediately, CPHA=1 on the first shift edge
    if (load_word) begin
      if (load_cpha) begin
        miso_nxt  = 1'b0;
        shift_nxt = tx_word;
      end else begin
        miso_nxt  = tx_word[W-1];
        shift_nxt = {tx_word[W-2:0], 1'b0};
      end
    end

`ifdef SPI_SLAVE_FRAME_ERROR_EN
    // Stale: a load reused the holding register with no host write since the last load
    if (host.i_tx_load) begin
      stale_nxt = 1'b0;
      fresh_nxt = 1'b1;
    end else if (load_word) begin
      stale_nxt = ~fresh_q;
      fresh_nxt = 1'b0;
    end
`endif
  end

  // State and datapath registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      shift_q  <= '0;
      rx_q     <= '0;
      dout_q   <= '0;
      cnt_q    <= '0;
      miso_q   <= 1'b0;
      valid_q  <= 1'b0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      reload_q <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERROR_EN
      ferr_q   <= 1'b0;
      stale_q  <= 1'b0;
      fresh_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_nxt;
      hold_q   <= hold_nxt;
      shift_q  <= shift_nxt;
      rx_q     <= rx_nxt;
      dout_q   <= dout_nxt;
      cnt_q    <= cnt_nxt;
      miso_q   <= miso_nxt;
      valid_q  <= valid_nxt;
      cpol_q   <= cpol_nxt;
      cpha_q   <= cpha_nxt;
      reload_q <= reload_nxt;
`ifdef SPI_SLAVE_FRAME_ERROR_EN
      ferr_q   <= ferr_nxt;
      stale_q  <= stale_nxt;
      fresh_q  <= fresh_nxt;
`endif
    end
  end

  assign host.o_data_out   = dout_q;
  assign host.o_data_valid = valid_q;
  assign host.o_busy       = (state_q == ACTIVE);
  assign o_spi_miso        = miso_q;
  assign o_spi_miso_oe     = (state_q == ACTIVE);
`ifdef SPI_SLAVE_FRAME_ERROR_EN
  assign o_frame_error     = ferr_q;
  assign o_tx_stale        = stale_q;
`endif
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed bench for spi_slave acting as the SPI master.
// SCLK period is 16 system clocks; all four modes, back-to-back words,
// partial frame, mid-frame reset and SCLK activity outside CS are exercised.
module tb_spi_slave;
  localparam int unsigned W    = 32;
  localparam int          HALF = 8;

  logic clk = 1'b0;
  logic rst, cpol, cpha, cs_n, sclk, mosi;
  logic miso, oe;
`ifdef SPI_SLAVE_FRAME_ERROR_EN
  logic ferr, stale;
`endif

  spi_slave_if #(.SPI_DATA_WIDTH(W)) bus ();

  spi_slave #(.SPI_DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_clock_polarity (cpol),
    .i_clock_phase    (cpha),
    .host             (bus.slave),
    .i_spi_cs_n       (cs_n),
    .i_spi_clock      (sclk),
    .i_spi_mosi       (mosi),
    .o_spi_miso       (miso),
    .o_spi_miso_oe    (oe)
`ifdef SPI_SLAVE_FRAME_ERROR_EN
    ,
    .o_frame_error    (ferr),
    .o_tx_stale       (stale)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Output monitor
  int             valid_cnt = 0;
  int             fe_cnt    = 0;
  int             oe_bad    = 0;
  int             cs_hi     = 0;
  logic [W-1:0]   words[$];

  always @(negedge clk) begin
    if (bus.o_data_valid === 1'b1) begin
      valid_cnt++;
      words.push_back(bus.o_data_out);
    end
`ifdef SPI_SLAVE_FRAME_ERROR_EN
    if (ferr === 1'b1) fe_cnt++;
`endif
    if (cs_n === 1'b1) begin
      if (cs_hi < 1000) cs_hi++;
    end else begin
      cs_hi = 0;
    end
    if (oe === 1'b1 && cs_hi > 5) oe_bad++;
  end

  task automatic host_load(input logic [W-1:0] v);
    bus.i_data_in = v;
    bus.i_tx_load = 1'b1;
    @(negedge clk);
    bus.i_tx_load = 1'b0;
  endtask

  // Half SCLK period, optionally with a host load or a reset pulse in its first cycle
  task automatic half_wait(input bit do_load, input logic [W-1:0] v, input bit do_rst);
    if (do_load) begin
      host_load(v);
      repeat (HALF - 1) @(negedge clk);
    end else if (do_rst) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid_busy",  64'(bus.o_busy),       64'd0);
      check("rst_mid_oe",    64'(oe),               64'd0);
      check("rst_mid_valid", 64'(bus.o_data_valid), 64'd0);
      check("rst_mid_dout",  64'(bus.o_data_out),   64'd0);
      check("rst_mid_miso",  64'(miso),             64'd0);
      repeat (HALF - 1) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
  endtask

  // One CS frame of nbits, MSB first; rx collects MISO at the master's sample edges
  task automatic xfer(input bit pol, input bit pha, input logic [63:0] tx, input int nbits,
                      input int load_at, input logic [W-1:0] load_val, input int rst_at,
                      output logic [63:0] rx);
    rx   = '0;
    cpol = pol;
    cpha = pha;
    sclk = pol;
    repeat (HALF) @(negedge clk);
    cs_n = 1'b0;
    repeat (2 * HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == 16) begin
        check("oe_in_frame",   64'(oe),         64'd1);
        check("busy_in_frame", 64'(bus.o_busy), 64'd1);
      end
      if (!pha) begin
        mosi = tx[nbits-1-i];
        half_wait(i == load_at, load_val, i == rst_at);
        sclk = ~pol;
        rx   = {rx[62:0], miso};
        half_wait(1'b0, '0, 1'b0);
        sclk = pol;
      end else begin
        sclk = ~pol;
        mosi = tx[nbits-1-i];
        half_wait(i == load_at, load_val, i == rst_at);
        sclk = pol;
        rx   = {rx[62:0], miso};
        half_wait(1'b0, '0, 1'b0);
      end
    end
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  initial begin
    logic [63:0] rx;
    int          v0;
    int          f0;
    logic [1:0]  m;

    rst = 1'b1; cpol = 1'b0; cpha = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    bus.i_tx_load = 1'b0;
    bus.i_data_in = '0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_dout",  64'(bus.o_data_out),   64'd0);
    check("reset_valid", 64'(bus.o_data_valid), 64'd0);
    check("reset_busy",  64'(bus.o_busy),       64'd0);
    check("reset_miso",  64'(miso),             64'd0);
    check("reset_oe",    64'(oe),               64'd0);
`ifdef SPI_SLAVE_FRAME_ERROR_EN
    check("reset_ferr",  64'(ferr),             64'd0);
    check("reset_stale", 64'(stale),            64'd0);
`endif

    // All four modes, holding register sticky across frames
    host_load(32'hA5A5_0F0F);
    for (int k = 0; k < 4; k++) begin
      m  = 2'(k);
      v0 = valid_cnt;
      f0 = fe_cnt;
      xfer(m[1], m[0], 64'h1234_5678, 32, -1, '0, -1, rx);
      check($sformatf("m%0d_valid_cnt", k), 64'(valid_cnt - v0), 64'd1);
      check($sformatf("m%0d_dout", k),      64'(bus.o_data_out),  64'h1234_5678);
      check($sformatf("m%0d_miso_word", k), rx,                   64'hA5A5_0F0F);
      check($sformatf("m%0d_busy_after", k), 64'(bus.o_busy),     64'd0);
      check($sformatf("m%0d_oe_after", k),  64'(oe),              64'd0);
`ifdef SPI_SLAVE_FRAME_ERROR_EN
      check($sformatf("m%0d_ferr_cnt", k),  64'(fe_cnt - f0),     64'd0);
      check($sformatf("m%0d_stale", k),     64'(stale),           (k == 0) ? 64'd0 : 64'd1);
`endif
    end

    // Two words per frame, CPHA=0: host rewrites holding during word 1
    v0 = valid_cnt;
    words.delete();
    xfer(1'b0, 1'b0, 64'h1234_5678_CAFE_F00D, 64, 5, 32'hDEAD_BEEF, -1, rx);
    check("b2b0_valid_cnt", 64'(valid_cnt - v0), 64'd2);
    check("b2b0_word0",     64'(words[0]),       64'h1234_5678);
    check("b2b0_word1",     64'(words[1]),       64'hCAFE_F00D);
    check("b2b0_miso",      rx,                  64'hA5A5_0F0F_DEAD_BEEF);
`ifdef SPI_SLAVE_FRAME_ERROR_EN
    check("b2b0_stale",     64'(stale),          64'd0);
`endif

    // Two words per frame, CPHA=1 (mode 3)
    v0 = valid_cnt;
    words.delete();
    xfer(1'b1, 1'b1, 64'hFEDC_BA98_7654_3210, 64, 5, 32'h0BAD_F00D, -1, rx);
    check("b2b3_valid_cnt", 64'(valid_cnt - v0), 64'd2);
    check("b2b3_word0",     64'(words[0]),       64'hFEDC_BA98);
    check("b2b3_word1",     64'(words[1]),       64'h7654_3210);
    check("b2b3_miso",      rx,                  64'hDEAD_BEEF_0BAD_F00D);

    // Partial frame: 13 bits, no valid, last word kept
    v0 = valid_cnt;
    f0 = fe_cnt;
    xfer(1'b0, 1'b0, 64'h1ABC, 13, -1, '0, -1, rx);
    check("part_valid_cnt", 64'(valid_cnt - v0), 64'd0);
    check("part_dout",      64'(bus.o_data_out), 64'h7654_3210);
`ifdef SPI_SLAVE_FRAME_ERROR_EN
    check("part_ferr_cnt",  64'(fe_cnt - f0),    64'd1);
`endif

    // Reset at bit 20: rest of that frame ignored, next frame clean
    v0 = valid_cnt;
    xfer(1'b0, 1'b0, 64'h1111_2222, 32, -1, '0, 20, rx);
    check("rst_frame_valid", 64'(valid_cnt - v0), 64'd0);
    check("rst_frame_dout",  64'(bus.o_data_out), 64'd0);
    check("rst_frame_busy",  64'(bus.o_busy),     64'd0);
    host_load(32'h5A5A_C3C3);
    v0 = valid_cnt;
    xfer(1'b1, 1'b0, 64'h8765_4321, 32, -1, '0, -1, rx);
    check("post_rst_valid", 64'(valid_cnt - v0), 64'd1);
    check("post_rst_dout",  64'(bus.o_data_out), 64'h8765_4321);
    check("post_rst_miso",  rx,                  64'h5A5A_C3C3);

    // SCLK activity while deselected
    v0 = valid_cnt;
    cs_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      sclk = ~sclk;
      mosi = ~mosi;
      repeat (4) @(negedge clk);
    end
    check("idle_sclk_valid", 64'(valid_cnt - v0), 64'd0);
    check("idle_sclk_oe",    64'(oe),             64'd0);
    check("idle_sclk_busy",  64'(bus.o_busy),     64'd0);
    v0 = valid_cnt;
    xfer(1'b0, 1'b1, 64'h0F0F_1234, 32, -1, '0, -1, rx);
    check("after_idle_valid", 64'(valid_cnt - v0), 64'd1);
    check("after_idle_dout",  64'(bus.o_data_out), 64'h0F0F_1234);
    check("after_idle_miso",  rx,                  64'h5A5A_C3C3);

    check("oe_outside_cs", 64'(oe_bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
